// File: rtl/opb_pkg.sv
// opb_pkg: sizing helpers, stream FSM state type and matrix-select encoding shared by operand_bank.
package opb_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_BUS_WIDTH  = 64;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } opb_state_e;

    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    function automatic int calc_dim_w(input int max_dim);
        return (max_dim > 1) ? $clog2(max_dim) : 1;
    endfunction

endpackage

// File: rtl/opb_row_mask.sv
// opb_row_mask: zeroes the elements of one matrix row that fall outside the active
// (row_lim, col_lim) window; purely combinational.
module opb_row_mask
    import opb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_DIM    = calc_max_dim(DEF_BUS_WIDTH, DEF_DATA_WIDTH),
    parameter int DIM_W      = calc_dim_w(MAX_DIM)
) (
    input  logic [MAX_DIM*DATA_WIDTH-1:0] i_row,
    input  logic [DIM_W-1:0]              i_rowIdx,
    input  logic [DIM_W-1:0]              i_rowLim,
    input  logic [DIM_W-1:0]              i_colLim,
    output logic [MAX_DIM*DATA_WIDTH-1:0] o_row
);

    always_comb begin
        o_row = '0;
        if (i_rowIdx <= i_rowLim) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (DIM_W'(e) <= i_colLim) begin
                    o_row[e*DATA_WIDTH +: DATA_WIDTH] = i_row[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/operand_bank.sv
// operand_bank: A/B operand rows with strobed host writes, masked readback and a valid/ready row stream.
// Define OPB_PINGPONG_EN for separate load/stream sets that swap on every accepted start.
module operand_bank
    import opb_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  BUS_WIDTH  = DEF_BUS_WIDTH,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int DIM_W      = calc_dim_w(MAX_DIM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [DIM_W-1:0]     wr_row,
    input  logic [MAX_DIM-1:0]   wr_strb,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic                 rd_sel,
    input  logic [DIM_W-1:0]     rd_row,
    output logic [BUS_WIDTH-1:0] rd_data,
    input  logic                 clear,
    input  logic [DIM_W-1:0]     dim_n,
    input  logic [DIM_W-1:0]     dim_k,
    input  logic [DIM_W-1:0]     dim_m,
    input  logic                 start,
    output logic                 a_valid,
    output logic                 b_valid,
    output logic [BUS_WIDTH-1:0] a_data,
    output logic [BUS_WIDTH-1:0] b_data,
    input  logic                 stream_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 start_err,
    output logic                 wr_err
);

    localparam logic [DIM_W-1:0] LAST_BEAT = DIM_W'(MAX_DIM - 1);

`ifdef OPB_PINGPONG_EN
    localparam int NSETS = 2;
`else
    localparam int NSETS = 1;
`endif

    logic [BUS_WIDTH-1:0] r_memA [NSETS][MAX_DIM];
    logic [BUS_WIDTH-1:0] r_memB [NSETS][MAX_DIM];

    opb_state_e           r_state, w_nextState;
    logic [DIM_W-1:0]     r_dimN, r_dimK, r_dimM;
    logic [DIM_W-1:0]     r_beat;
    logic                 r_valid;
    logic [BUS_WIDTH-1:0] r_aData, r_bData;
    logic                 r_startErr, r_wrErr;

    logic                 w_loadSet, w_streamSet;
    logic                 w_startAcc, w_hostDropped;
    logic [DIM_W-1:0]     w_streamRow;
    logic [BUS_WIDTH-1:0] w_rdRaw, w_aMasked, w_bMasked;
    logic [DIM_W-1:0]     w_rdRowLim, w_rdColLim;

    assign w_startAcc = start && (r_state == IDLE);

`ifdef OPB_PINGPONG_EN
    logic r_loadSet;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loadSet <= 1'b0;
        end else if (w_startAcc) begin
            r_loadSet <= ~r_loadSet;
        end
    end

    assign w_loadSet     = r_loadSet;
    assign w_streamSet   = ~r_loadSet;
    assign w_hostDropped = 1'b0;
`else
    assign w_loadSet     = 1'b0;
    assign w_streamSet   = 1'b0;
    assign w_hostDropped = (wr_en || clear) && (r_state == STREAM);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSETS; s++) begin
                for (int r = 0; r < MAX_DIM; r++) begin
                    r_memA[s][r] <= '0;
                    r_memB[s][r] <= '0;
                end
            end
        end else if (clear && !w_hostDropped) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                r_memA[w_loadSet][r] <= '0;
                r_memB[w_loadSet][r] <= '0;
            end
        end else if (wr_en && !w_hostDropped) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (wr_strb[e]) begin
                    if (wr_sel == SEL_A) begin
                        r_memA[w_loadSet][wr_row][e*DATA_WIDTH +: DATA_WIDTH] <= wr_data[e*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        r_memB[w_loadSet][wr_row][e*DATA_WIDTH +: DATA_WIDTH] <= wr_data[e*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Readback masks with the live dimensions; the stream uses the copy latched at start.
    assign w_rdRaw    = (rd_sel == SEL_B) ? r_memB[w_loadSet][rd_row] : r_memA[w_loadSet][rd_row];
    assign w_rdRowLim = (rd_sel == SEL_B) ? dim_k : dim_n;
    assign w_rdColLim = (rd_sel == SEL_B) ? dim_m : dim_k;

    opb_row_mask #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_rdMask (
        .i_row(w_rdRaw), .i_rowIdx(rd_row), .i_rowLim(w_rdRowLim), .i_colLim(w_rdColLim), .o_row(rd_data)
    );

    assign w_streamRow = r_valid ? (r_beat + DIM_W'(1)) : r_beat;

    opb_row_mask #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_aMask (
        .i_row(r_memA[w_streamSet][w_streamRow]), .i_rowIdx(w_streamRow),
        .i_rowLim(r_dimN), .i_colLim(r_dimK), .o_row(w_aMasked)
    );

    opb_row_mask #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_bMask (
        .i_row(r_memB[w_streamSet][w_streamRow]), .i_rowIdx(w_streamRow),
        .i_rowLim(r_dimK), .i_colLim(r_dimM), .o_row(w_bMasked)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (start) w_nextState = STREAM;
            STREAM:  if (r_valid && stream_ready && (r_beat == LAST_BEAT)) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            STREAM:  busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The first beat is loaded one cycle after start; each later row loads as the previous one is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dimN     <= '0;
            r_dimK     <= '0;
            r_dimM     <= '0;
            r_beat     <= '0;
            r_valid    <= 1'b0;
            r_aData    <= '0;
            r_bData    <= '0;
            r_startErr <= 1'b0;
            r_wrErr    <= 1'b0;
        end else begin
            r_startErr <= start && (r_state != IDLE);
            r_wrErr    <= w_hostDropped;
            if (w_startAcc) begin
                r_dimN  <= dim_n;
                r_dimK  <= dim_k;
                r_dimM  <= dim_m;
                r_beat  <= '0;
                r_valid <= 1'b0;
            end else if (r_state == STREAM) begin
                if (!r_valid) begin
                    r_valid <= 1'b1;
                    r_aData <= w_aMasked;
                    r_bData <= w_bMasked;
                end else if (stream_ready) begin
                    if (r_beat == LAST_BEAT) begin
                        r_valid <= 1'b0;
                        r_aData <= '0;
                        r_bData <= '0;
                    end else begin
                        r_beat  <= w_streamRow;
                        r_aData <= w_aMasked;
                        r_bData <= w_bMasked;
                    end
                end
            end
        end
    end

    assign a_valid   = r_valid;
    assign b_valid   = r_valid;
    assign a_data    = r_aData;
    assign b_data    = r_bData;
    assign start_err = r_startErr;
    assign wr_err    = r_wrErr;

endmodule
